// File: rtl/harris_pkg.sv
// Shared constants, coordinate type, window tag and raster FSM encoding
// for the Harris window sequencer.
package harris_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int WIN_DEF      = 5;
    localparam int COORD_W      = 10;

    typedef logic [COORD_W-1:0] coord_t;

    localparam logic [1:0] S_VSYNC  = 2'd0;
    localparam logic [1:0] S_LINE   = 2'd1;
    localparam logic [1:0] S_HBLANK = 2'd2;

    // Qualify flag plus window-centre coordinate, carried through the latency pipe.
    typedef struct packed {
        logic   valid;
        coord_t x;
        coord_t y;
    } win_tag_t;

endpackage

// File: rtl/harris_window_sequencer_if.sv
// Video-timing and datapath-facing signals of the window sequencer.
// master = sequencer side, slave = VGA timing / line-buffer / harris side.
interface harris_window_sequencer_if;
    import harris_pkg::*;

    logic   VGA_BLANK;
    logic   VGA_VS;
    logic   corner_raw;
    logic   buf_shift_en;
    logic   buf_aclr;
    logic   win_valid;
    coord_t win_x;
    coord_t win_y;
    logic   corner_detected;

    modport master (
        input  VGA_BLANK, VGA_VS, corner_raw,
        output buf_shift_en, buf_aclr, win_valid, win_x, win_y, corner_detected
    );

    modport slave (
        output VGA_BLANK, VGA_VS, corner_raw,
        input  buf_shift_en, buf_aclr, win_valid, win_x, win_y, corner_detected
    );

endinterface

// File: rtl/harris_latency_pipe.sv
// LATENCY-stage shift register aligning window tags with the harris output;
// a synchronous flush invalidates every in-flight entry.
module harris_latency_pipe
    import harris_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     flush,
    input  win_tag_t din,
    output win_tag_t dout
);

    win_tag_t stage [LATENCY];

    // NOTE: these stages are a handful of flops, not a RAM, so resetting them is cheap
    // and keeps win_valid clean after reset; <= keeps every stage sampling the old value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[LATENCY-1];

endmodule

// File: rtl/harris_window_sequencer.sv
// Raster sequencer and per-frame corner statistics for the Harris pipeline.
// Define HARRIS_BBOX_EN to add the per-frame corner bounding-box outputs.
module harris_window_sequencer
    import harris_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int WIN      = WIN_DEF,
    parameter int LATENCY  = 3,
    parameter int CNT_W    = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    harris_window_sequencer_if.master vid,
    output logic                     frame_done,
    output logic                     frame_corner_valid,
    output coord_t                   frame_first_x,
    output coord_t                   frame_first_y,
    output logic [CNT_W-1:0]         frame_count
`ifdef HARRIS_BBOX_EN
    ,
    output coord_t                   frame_min_x,
    output coord_t                   frame_max_x,
    output coord_t                   frame_min_y,
    output coord_t                   frame_max_y
`endif
);

    localparam coord_t           H_MAX   = coord_t'(H_ACTIVE);
    localparam coord_t           V_MAX   = coord_t'(V_ACTIVE);
    localparam coord_t           EDGE    = coord_t'(WIN - 1);
    localparam coord_t           OFS     = coord_t'(WIN / 2);
    localparam coord_t           ONE     = coord_t'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0] state, state_nxt;
    coord_t     col, row;
    logic       shift_cond, win_full, vs_fall, hit;
    win_tag_t   tag_in, tag_out;

    assign shift_cond = (state == S_LINE) && (col < H_MAX) && (row < V_MAX);
    assign win_full   = (col >= EDGE) && (row >= EDGE);
    assign vs_fall    = !vid.VGA_VS && (state != S_VSYNC);

    // NOTE: state_nxt gets a default before the case so no path leaves it unassigned.
    always_comb begin
        state_nxt = state;
        if (!vid.VGA_VS) begin
            state_nxt = S_VSYNC;
        end else begin
            case (state)
                S_VSYNC:  state_nxt = vid.VGA_BLANK ? S_LINE : S_HBLANK;
                S_LINE:   if (!vid.VGA_BLANK) state_nxt = S_HBLANK;
                S_HBLANK: if (vid.VGA_BLANK) state_nxt = S_LINE;
                default:  state_nxt = S_VSYNC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_VSYNC;
            col              <= '0;
            row              <= '0;
            vid.buf_shift_en <= 1'b0;
            vid.buf_aclr     <= 1'b0;
            tag_in           <= '0;
        end else begin
            state            <= state_nxt;
            vid.buf_shift_en <= shift_cond;
            vid.buf_aclr     <= ~vid.VGA_VS;
            tag_in           <= '{valid: shift_cond && win_full, x: col - OFS, y: row - OFS};
            case (state_nxt)
                S_VSYNC: begin
                    col <= '0;
                    row <= '0;
                end
                S_HBLANK: begin
                    // Row advances once per line that actually carried pixels.
                    if (state != S_HBLANK && col != '0 && row < V_MAX) row <= row + ONE;
                    col <= '0;
                end
                default: begin
                    if (state == S_LINE && col < H_MAX) col <= col + ONE;
                end
            endcase
        end
    end

    harris_latency_pipe #(.LATENCY(LATENCY)) u_pipe (
        .clk   (clk),
        .reset (reset),
        .flush (state == S_VSYNC),
        .din   (tag_in),
        .dout  (tag_out)
    );

    assign vid.win_valid       = tag_out.valid;
    assign vid.win_x           = tag_out.x;
    assign vid.win_y           = tag_out.y;
    assign vid.corner_detected = vid.corner_raw & tag_out.valid;
    assign hit                 = vid.corner_detected;

    // Accumulators merged with this cycle's hit, so a hit on the VS edge lands in the closing frame.
    logic             acc_valid, m_valid;
    coord_t           acc_fx, acc_fy, m_fx, m_fy;
    logic [CNT_W-1:0] acc_cnt, m_cnt;

    always_comb begin
        m_valid = acc_valid | hit;
        m_fx    = acc_valid ? acc_fx : (hit ? vid.win_x : '0);
        m_fy    = acc_valid ? acc_fy : (hit ? vid.win_y : '0);
        m_cnt   = (hit && acc_cnt != '1) ? acc_cnt + CNT_ONE : acc_cnt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_valid          <= 1'b0;
            acc_fx             <= '0;
            acc_fy             <= '0;
            acc_cnt            <= '0;
            frame_done         <= 1'b0;
            frame_corner_valid <= 1'b0;
            frame_first_x      <= '0;
            frame_first_y      <= '0;
            frame_count        <= '0;
        end else if (vs_fall) begin
            acc_valid          <= 1'b0;
            acc_fx             <= '0;
            acc_fy             <= '0;
            acc_cnt            <= '0;
            frame_done         <= 1'b1;
            frame_corner_valid <= m_valid;
            frame_first_x      <= m_fx;
            frame_first_y      <= m_fy;
            frame_count        <= m_cnt;
        end else begin
            acc_valid          <= m_valid;
            acc_fx             <= m_fx;
            acc_fy             <= m_fy;
            acc_cnt            <= m_cnt;
            frame_done         <= 1'b0;
        end
    end

`ifdef HARRIS_BBOX_EN
    coord_t acc_min_x, acc_max_x, acc_min_y, acc_max_y;
    coord_t m_min_x, m_max_x, m_min_y, m_max_y;

    always_comb begin
        m_min_x = acc_min_x;
        m_max_x = acc_max_x;
        m_min_y = acc_min_y;
        m_max_y = acc_max_y;
        if (hit) begin
            if (vid.win_x < acc_min_x) m_min_x = vid.win_x;
            if (vid.win_x > acc_max_x) m_max_x = vid.win_x;
            if (vid.win_y < acc_min_y) m_min_y = vid.win_y;
            if (vid.win_y > acc_max_y) m_max_y = vid.win_y;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_min_x   <= '1;
            acc_max_x   <= '0;
            acc_min_y   <= '1;
            acc_max_y   <= '0;
            frame_min_x <= '0;
            frame_max_x <= '0;
            frame_min_y <= '0;
            frame_max_y <= '0;
        end else if (vs_fall) begin
            acc_min_x   <= '1;
            acc_max_x   <= '0;
            acc_min_y   <= '1;
            acc_max_y   <= '0;
            frame_min_x <= m_valid ? m_min_x : '0;
            frame_max_x <= m_valid ? m_max_x : '0;
            frame_min_y <= m_valid ? m_min_y : '0;
            frame_max_y <= m_valid ? m_max_y : '0;
        end else begin
            acc_min_x   <= m_min_x;
            acc_max_x   <= m_max_x;
            acc_min_y   <= m_min_y;
            acc_max_y   <= m_max_y;
        end
    end
`endif

endmodule

// File: tb/tb_harris_window_sequencer.sv
// Directed testbench for harris_window_sequencer; expected values are hand-derived
// from the raster FSM (shift of column c appears c+2 cycles after BLANK rises).
module tb_harris_window_sequencer;
    import harris_pkg::*;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    harris_window_sequencer_if vid();

    logic        frame_done, frame_corner_valid;
    coord_t      frame_first_x, frame_first_y;
    logic [11:0] frame_count;
`ifdef HARRIS_BBOX_EN
    coord_t      frame_min_x, frame_max_x, frame_min_y, frame_max_y;
`endif

    harris_window_sequencer #(.LATENCY(LAT), .CNT_W(12)) dut (
        .clk                (clk),
        .reset              (reset),
        .vid                (vid),
        .frame_done         (frame_done),
        .frame_corner_valid (frame_corner_valid),
        .frame_first_x      (frame_first_x),
        .frame_first_y      (frame_first_y),
        .frame_count        (frame_count)
`ifdef HARRIS_BBOX_EN
        ,
        .frame_min_x        (frame_min_x),
        .frame_max_x        (frame_max_x),
        .frame_min_y        (frame_min_y),
        .frame_max_y        (frame_max_y)
`endif
    );

    int checks = 0;
    int errors = 0;

    // First win_valid seen in the current frame, located by line index and tick within the line.
    int     cur_line;
    bit     seen_win;
    int     first_win_line, first_win_i;
    coord_t first_wx, first_wy;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        vid.VGA_VS    = 1'b0;
        vid.VGA_BLANK = 1'b0;
        repeat (4) tick();
        vid.VGA_VS = 1'b1;
        repeat (5) tick();
        cur_line = 0;
        seen_win = 1'b0;
    endtask

    // One active line of n BLANK-high cycles followed by blank_n BLANK-low cycles.
    // pulse_i != 0 drives corner_raw for exactly the cycle after tick pulse_i.
    task automatic run_line(input int n, input int blank_n, input bit corner_all, input int pulse_i);
        vid.VGA_BLANK  = 1'b1;
        vid.corner_raw = (pulse_i != 0) ? 1'b0 : corner_all;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (pulse_i != 0) vid.corner_raw = (i == pulse_i);
            if (!seen_win && vid.win_valid === 1'b1) begin
                seen_win       = 1'b1;
                first_win_line = cur_line;
                first_win_i    = i;
                first_wx       = vid.win_x;
                first_wy       = vid.win_y;
            end
        end
        vid.VGA_BLANK = 1'b0;
        if (pulse_i != 0) vid.corner_raw = 1'b0;
        repeat (blank_n) tick();
        cur_line++;
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        vid.VGA_VS     = 1'b0;
        vid.VGA_BLANK  = 1'b0;
        vid.corner_raw = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        vid.VGA_VS = 1'b1;
        repeat (3) tick();
        vid.VGA_BLANK = 1'b1;
        repeat (20) tick();
        checks++;
        if (vid.buf_shift_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_midline_shift: got %b expected 1", vid.buf_shift_en);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({vid.buf_shift_en, vid.buf_aclr, vid.win_valid, vid.win_x, vid.win_y, frame_done,
             frame_corner_valid, frame_first_x, frame_first_y, frame_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: shift=%b aclr=%b wv=%b wx=%0d wy=%0d fd=%b fcv=%b fx=%0d fy=%0d cnt=%0d expected all 0",
                     vid.buf_shift_en, vid.buf_aclr, vid.win_valid, vid.win_x, vid.win_y, frame_done,
                     frame_corner_valid, frame_first_x, frame_first_y, frame_count);
        end
        vid.VGA_VS    = 1'b0;
        vid.VGA_BLANK = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (vid.buf_shift_en !== 1'b0 || vid.buf_aclr !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_vsync: shift=%b aclr=%b expected shift=0 aclr=1", vid.buf_shift_en, vid.buf_aclr);
        end
        vid.VGA_VS = 1'b1;
        repeat (3) tick();
        checks++;
        if (vid.buf_shift_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_vs_high_no_shift: got %b expected 0", vid.buf_shift_en);
        end
        vid.VGA_BLANK = 1'b1;
        tick();
        checks++;
        if (vid.buf_shift_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_blank_entry_shift: got %b expected 0", vid.buf_shift_en);
        end
        tick();
        checks++;
        if (vid.buf_shift_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_shift: got %b expected 1", vid.buf_shift_en);
        end
        vid.VGA_BLANK = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_line_shift();
        int cnt = 0;
        int first = -1;
        int last = -1;
        start_frame();
        vid.VGA_BLANK = 1'b1;
        for (int i = 1; i <= 720; i++) begin
            tick();
            if (vid.buf_shift_en === 1'b1) begin
                cnt++;
                if (first < 0) first = i;
                last = i;
            end
            if (i == 700) vid.VGA_BLANK = 1'b0;
        end
        checks++;
        if (cnt != 640) begin
            errors++;
            $display("FAIL line_shift_count: got %0d expected 640", cnt);
        end
        checks++;
        if (first != 2 || last != 641) begin
            errors++;
            $display("FAIL line_shift_span: got first=%0d last=%0d expected first=2 last=641", first, last);
        end
    endtask

    task automatic test_full_frame();
        start_frame();
        vid.corner_raw = 1'b1;
        for (int l = 0; l < 12; l++) run_line(700, 20, 1'b1, 0);
        vid.VGA_VS = 1'b0;
        tick();
        checks++;
        if (!seen_win || first_win_line != 4 || first_win_i != 4 + 2 + LAT || first_wx != 2 || first_wy != 2) begin
            errors++;
            $display("FAIL full_first_window: got seen=%b line=%0d tick=%0d x=%0d y=%0d expected line=4 tick=%0d x=2 y=2",
                     seen_win, first_win_line, first_win_i, first_wx, first_wy, 4 + 2 + LAT);
        end
        checks++;
        if (frame_done !== 1'b1 || frame_corner_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_frame_done: got done=%b valid=%b expected 1 1", frame_done, frame_corner_valid);
        end
        checks++;
        if (frame_count !== 12'd4095) begin
            errors++;
            $display("FAIL full_count_saturate: got %0d expected 4095", frame_count);
        end
        checks++;
        if (frame_first_x !== 10'd2 || frame_first_y !== 10'd2) begin
            errors++;
            $display("FAIL full_first_corner: got (%0d,%0d) expected (2,2)", frame_first_x, frame_first_y);
        end
`ifdef HARRIS_BBOX_EN
        checks++;
        if (frame_min_x !== 10'd2 || frame_max_x !== 10'd637 || frame_min_y !== 10'd2 || frame_max_y !== 10'd9) begin
            errors++;
            $display("FAIL full_bbox: got x[%0d,%0d] y[%0d,%0d] expected x[2,637] y[2,9]",
                     frame_min_x, frame_max_x, frame_min_y, frame_max_y);
        end
`endif
        tick();
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL full_done_pulse_width: got %b expected 0", frame_done);
        end
        vid.corner_raw = 1'b0;
    endtask

    task automatic test_count_exact();
        start_frame();
        vid.corner_raw = 1'b1;
        for (int l = 0; l < 6; l++) run_line(700, 20, 1'b1, 0);
        vid.VGA_VS = 1'b0;
        tick();
        vid.corner_raw = 1'b0;
        checks++;
        if (frame_done !== 1'b1 || frame_count !== 12'd1272) begin
            errors++;
            $display("FAIL count_exact: got done=%b count=%0d expected done=1 count=1272", frame_done, frame_count);
        end
    endtask

    task automatic test_single_pulse();
        start_frame();
        vid.corner_raw = 1'b0;
        for (int l = 0; l < 53; l++) run_line(110, 10, 1'b0, (l == 52) ? 102 + 2 + LAT : 0);
        vid.VGA_VS = 1'b0;
        tick();
        checks++;
        if (frame_done !== 1'b1 || frame_corner_valid !== 1'b1 || frame_count !== 12'd1) begin
            errors++;
            $display("FAIL pulse_frame: got done=%b valid=%b count=%0d expected 1 1 1", frame_done, frame_corner_valid, frame_count);
        end
        checks++;
        if (frame_first_x !== 10'd100 || frame_first_y !== 10'd50) begin
            errors++;
            $display("FAIL pulse_first_corner: got (%0d,%0d) expected (100,50)", frame_first_x, frame_first_y);
        end
`ifdef HARRIS_BBOX_EN
        checks++;
        if (frame_min_x !== 10'd100 || frame_max_x !== 10'd100 || frame_min_y !== 10'd50 || frame_max_y !== 10'd50) begin
            errors++;
            $display("FAIL pulse_bbox: got x[%0d,%0d] y[%0d,%0d] expected x[100,100] y[50,50]",
                     frame_min_x, frame_max_x, frame_min_y, frame_max_y);
        end
`endif
        tick();
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL pulse_done_pulse_width: got %b expected 0", frame_done);
        end
    endtask

    task automatic test_vs_edge_corner();
        start_frame();
        vid.corner_raw = 1'b0;
        for (int l = 0; l < 4; l++) run_line(30, 10, 1'b0, 0);
        vid.VGA_BLANK = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            vid.corner_raw = (i == 11) || (i == 20);
            if (i == 20) begin
                checks++;
                if (vid.win_valid !== 1'b1 || vid.win_x !== 10'd13 || vid.win_y !== 10'd2) begin
                    errors++;
                    $display("FAIL edge_window_before_vs: got wv=%b (%0d,%0d) expected wv=1 (13,2)",
                             vid.win_valid, vid.win_x, vid.win_y);
                end
                vid.VGA_VS = 1'b0;
            end
        end
        tick();
        vid.corner_raw = 1'b0;
        vid.VGA_BLANK  = 1'b0;
        checks++;
        if (frame_done !== 1'b1 || frame_count !== 12'd2 || frame_corner_valid !== 1'b1) begin
            errors++;
            $display("FAIL edge_frame: got done=%b count=%0d valid=%b expected 1 2 1", frame_done, frame_count, frame_corner_valid);
        end
        checks++;
        if (frame_first_x !== 10'd4 || frame_first_y !== 10'd2) begin
            errors++;
            $display("FAIL edge_first_corner: got (%0d,%0d) expected (4,2)", frame_first_x, frame_first_y);
        end
`ifdef HARRIS_BBOX_EN
        checks++;
        if (frame_min_x !== 10'd4 || frame_max_x !== 10'd13 || frame_min_y !== 10'd2 || frame_max_y !== 10'd2) begin
            errors++;
            $display("FAIL edge_bbox: got x[%0d,%0d] y[%0d,%0d] expected x[4,13] y[2,2]",
                     frame_min_x, frame_max_x, frame_min_y, frame_max_y);
        end
`endif
        repeat (2) tick();
        checks++;
        if (vid.win_valid !== 1'b0 || vid.buf_aclr !== 1'b1 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL edge_vsync_flush: got wv=%b aclr=%b done=%b expected 0 1 0", vid.win_valid, vid.buf_aclr, frame_done);
        end
    endtask

    task automatic test_no_corners();
        start_frame();
        vid.corner_raw = 1'b0;
        for (int l = 0; l < 6; l++) run_line(30, 10, 1'b0, 0);
        vid.VGA_VS = 1'b0;
        tick();
        checks++;
        if (frame_done !== 1'b1 || frame_corner_valid !== 1'b0 || frame_count !== 12'd0) begin
            errors++;
            $display("FAIL empty_frame: got done=%b valid=%b count=%0d expected 1 0 0", frame_done, frame_corner_valid, frame_count);
        end
        checks++;
        if (frame_first_x !== 10'd0 || frame_first_y !== 10'd0) begin
            errors++;
            $display("FAIL empty_first_corner: got (%0d,%0d) expected (0,0)", frame_first_x, frame_first_y);
        end
`ifdef HARRIS_BBOX_EN
        checks++;
        if ({frame_min_x, frame_max_x, frame_min_y, frame_max_y} !== '0) begin
            errors++;
            $display("FAIL empty_bbox: got x[%0d,%0d] y[%0d,%0d] expected all 0",
                     frame_min_x, frame_max_x, frame_min_y, frame_max_y);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_line_shift();
        test_full_frame();
        test_count_exact();
        test_single_pulse();
        test_vs_edge_corner();
        test_no_corners();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/harris_window_sequencer.md
Name: harris_window_sequencer

Overview:
Raster sequencer and result collector for the Harris corner pipeline, placed between the VGA timing signals and the line-buffer/sobel/harris datapath. Generates line-buffer shift enable and clear. Qualifies which 5x5 windows are fully populated and tags each harris result with its window-centre coordinate, compensating for pipeline latency. Collects per-frame corner statistics and publishes them at vertical sync.

Parameters:
H_ACTIVE, 640, active pixels per line; shift enable is suppressed beyond this count
V_ACTIVE, 480, active lines per frame; rows at or above this value are ignored
WIN, 5, window edge length; centre offset = WIN/2
LATENCY, 3, cycles from window shift to valid corner_raw at harris output (must be >= 1)
CNT_W, 12, width of the saturating per-frame corner counter

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-low reset
VGA_BLANK  in  1  high = active video pixel this cycle
VGA_VS  in  1  vertical sync, active-low
corner_raw  in  1  harris operator decision for the window shifted LATENCY cycles earlier
buf_shift_en  out  1  line-buffer shift enable (registered)
buf_aclr  out  1  line-buffer clear, high while VGA_VS low
win_valid  out  1  window aligned with corner_raw is fully populated
win_x  out  10  window-centre column aligned with corner_raw
win_y  out  10  window-centre row aligned with corner_raw
corner_detected  out  1  corner_raw AND win_valid
frame_done  out  1  one-cycle pulse when frame results update
frame_corner_valid  out  1  at least one corner was seen in the last completed frame
frame_first_x  out  10  column of the first corner in raster order, last frame
frame_first_y  out  10  row of the first corner in raster order, last frame
frame_count  out  CNT_W  corner count for the last frame, saturating

Behaviour:
- All registered outputs reset to 0. Reset is asynchronous; on deassertion the block waits in S_VSYNC.
- FSM states:
  - S_VSYNC: VGA_VS low. Transitions to S_LINE on VS high with BLANK high, or to S_HBLANK on VS high with BLANK low.
  - S_LINE: while BLANK high, col increments each cycle. Transitions to S_HBLANK on BLANK low.
  - S_HBLANK: on entry, row increments if col > 0; col is then cleared. Transitions to S_LINE on BLANK high.
  - VS low from any state forces S_VSYNC.
- Shift enable: buf_shift_en is asserted one cycle after a cycle in S_LINE with col < H_ACTIVE and row < V_ACTIVE. col saturates at H_ACTIVE. buf_aclr = ~VGA_VS, registered.
- Window qualification: a shift is window-complete when col >= WIN-1 and row >= WIN-1.
  - Centre coordinates are (col-WIN/2, row-WIN/2), computed in 10-bit unsigned arithmetic; only valid for complete windows.
  - The qualify flag and centre coordinates travel through a LATENCY-deep pipe and emerge as win_valid, win_x and win_y, aligned with corner_raw.
  - The pipe keeps advancing during blanking so that in-flight entries drain; it is flushed to invalid in S_VSYNC.
- Frame statistics: the accumulators are updated when corner_detected is high.
  - First-corner registers are loaded only on the first hit.
  - The counter increments and saturates at 2^CNT_W-1.
- VS falling edge, when the prior state was not S_VSYNC:
  - Copy the accumulators to the frame_* outputs and pulse frame_done for one cycle.
  - Clear the accumulators in the same cycle.
  - A corner_detected arriving in that same cycle is counted in the completed frame.
- A VS falling edge mid-line aborts the line; no partial-row correction is applied.
- A BLANK glitch shorter than one cycle cannot be detected; every BLANK low cycle is treated as HBLANK.

Optional Feature:
HARRIS_BBOX_EN
- Defined: adds outputs frame_min_x, frame_max_x, frame_min_y, frame_max_y (10 bits each), covering all corners of the last frame. They are published with frame_done. The accumulators reset to min=1023 and max=0; when no corners were seen, the published outputs are all 0.
- Undefined: these ports and their registers do not exist.

Decomposition:
- Shared package harris_pkg holds:
  - constants H_ACTIVE_DEF=640, V_ACTIVE_DEF=480, WIN_DEF=5, COORD_W=10;
  - typedef coord_t (10-bit unsigned);
  - the state encoding S_VSYNC, S_LINE, S_HBLANK.
- One sub-module, harris_latency_pipe: a parameterised LATENCY-stage shift register carrying {valid, x, y}, with a synchronous flush.

Test Plan:
- Reset low mid-line, then released → all outputs 0; no buf_shift_en until VS goes high and BLANK rises.
- One 640-pixel active line with BLANK held 700 cycles → buf_shift_en high for exactly 640 cycles, starting one cycle after BLANK rises.
- Full frame, corner_raw tied high → first win_valid with win_x=2, win_y=2 on row 4/col 4 shift + LATENCY; frame_count=(640-4)*(480-4)=302736 saturates to 4095; frame_first=(2,2).
- Single corner_raw pulse aligned to centre (100,50), then VS falls → frame_done one cycle; frame_corner_valid=1; frame_first=(100,50); frame_count=1.
- Frame with no corners → frame_corner_valid=0 and frame_count=0; under HARRIS_BBOX_EN, min/max outputs all 0.
- corner_raw high in the same cycle VS falls → counted in the completed frame; next frame's accumulators start at 0.
